// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: runs one FIR pass, streaming samples from memory through the
// filter core and writing results back, with busy/done, cycle count and errors.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, sel_pipelined   pass request (IDLE/DONE only) and core select
//   input_addr, output_addr, sample_count   pass parameters, latched on accept
//   mem_rd_*               read port; data returns one cycle after mem_rd_en
//   mem_wr_*               write port, fed straight from the core result
//   core_*                 filter core control, sample feed and result inputs
//   busy, done             RUN/DRAIN and DONE status
//   cycle_count            saturating cycle count of the last pass
//   err_timeout, err_extra sticky error flags, cleared on accept
module fir_seq_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              sel_pipelined,
   input  logic [ADDR_W-1:0] input_addr,
   input  logic [ADDR_W-1:0] output_addr,
   input  logic [ADDR_W-1:0] sample_count,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              core_sel,
   output logic              core_clr,
   output logic              core_in_valid,
   output logic [DATA_W-1:0] core_in_data,
   input  logic              core_in_ready,
   input  logic              core_out_valid,
   input  logic [DATA_W-1:0] core_out_data,
   output logic              busy,
   output logic              done,
   output logic [31:0]       cycle_count,
   output logic              err_timeout,
   output logic              err_extra
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] in_addr_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [ADDR_W-1:0] n_q;
   logic [ADDR_W-1:0] rd_cnt_q;
   logic [ADDR_W-1:0] rd_cnt_d;
   logic [ADDR_W-1:0] wr_cnt_q;
   logic [ADDR_W-1:0] wr_cnt_d;
   logic              sel_q;
   logic              clr_q;
   logic              inflight_q;
   logic              err_to_q;
   logic              err_ex_q;
   logic [DATA_W-1:0] fifo_q [2];
   logic              rptr_q;
   logic              wptr_q;
   logic [1:0]        cnt_q;
   logic [31:0]       cyc_q;
   logic [TW-1:0]     idle_q;

   logic              active;
   logic              fifo_push;
   logic              fifo_pop;
   logic [2:0]        used;
   logic              rd_en;
   logic              wr_hit;
   logic              extra;

   assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign fifo_push = inflight_q;
   assign fifo_pop  = active && (cnt_q != 2'd0) && core_in_ready;

   // Slots already committed after this cycle's pop: a pop frees its entry
   // in time for a new read, which keeps one read per cycle when ready.
   assign used = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, fifo_pop};

   assign rd_en  = (state_q == S_RUN) && (rd_cnt_q < n_q) && (used < 3'd2);
   assign wr_hit = active && core_out_valid && (wr_cnt_q < n_q);
   assign extra  = (state_q != S_IDLE) && core_out_valid && (wr_cnt_q == n_q);

   assign rd_cnt_d = rd_cnt_q + {{(ADDR_W-1){1'b0}}, rd_en};
   assign wr_cnt_d = wr_cnt_q + {{(ADDR_W-1){1'b0}}, wr_hit};

   assign mem_rd_en     = rd_en;
   assign mem_rd_addr   = rd_en ? (in_addr_q + rd_cnt_q) : '0;
   assign mem_wr_en     = wr_hit;
   assign mem_wr_addr   = wr_hit ? (out_addr_q + wr_cnt_q) : '0;
   assign mem_wr_data   = wr_hit ? core_out_data : '0;
   assign core_sel      = sel_q;
   assign core_clr      = clr_q;
   assign core_in_valid = active && (cnt_q != 2'd0);
   assign core_in_data  = core_in_valid ? fifo_q[rptr_q] : '0;
   assign busy          = active;
   assign done          = (state_q == S_DONE);
   assign cycle_count   = cyc_q;
   assign err_timeout   = err_to_q;
   assign err_extra     = err_ex_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         in_addr_q  <= '0;
         out_addr_q <= '0;
         n_q        <= '0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         sel_q      <= 1'b0;
         clr_q      <= 1'b0;
         inflight_q <= 1'b0;
         err_to_q   <= 1'b0;
         err_ex_q   <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         rptr_q     <= 1'b0;
         wptr_q     <= 1'b0;
         cnt_q      <= 2'd0;
         cyc_q      <= '0;
         idle_q     <= '0;
      end else begin
         clr_q      <= 1'b0;
         inflight_q <= rd_en;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         if (fifo_push) begin
            fifo_q[wptr_q] <= mem_rd_data;
            wptr_q         <= ~wptr_q;
         end
         if (fifo_pop) begin
            rptr_q <= ~rptr_q;
         end
         cnt_q <= cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
         if (active && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 32'd1;
         end
         if (extra) begin
            err_ex_q <= 1'b1;
         end
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  in_addr_q  <= input_addr;
                  out_addr_q <= output_addr;
                  n_q        <= sample_count;
                  sel_q      <= sel_pipelined;
                  rd_cnt_q   <= '0;
                  wr_cnt_q   <= '0;
                  rptr_q     <= 1'b0;
                  wptr_q     <= 1'b0;
                  cnt_q      <= 2'd0;
                  cyc_q      <= '0;
                  err_to_q   <= 1'b0;
                  err_ex_q   <= 1'b0;
                  idle_q     <= '0;
                  if (sample_count == '0) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_RUN;
                     clr_q   <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               idle_q <= '0;
               if (rd_cnt_d == n_q) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (wr_cnt_d == n_q) begin
                  state_q <= S_DONE;
               end else if (core_out_valid) begin
                  idle_q <= '0;
               end else if (idle_q == IDLE_LAST) begin
                  err_to_q <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  idle_q <= idle_q + TW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
